// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic valid/ready pipeline-stage register.
//
// Holds one beat of WIDTH bits between two pipeline stages. The output shows
// BUBBLE_VAL whenever no valid beat is held. For instruction payloads this is
// 32'h0000_0013, the NOP encoding. flush inserts a bubble on the next cycle.
//
//   SKID_EN = 0 : a single register. in_ready is combinational:
//                 in_ready = ~out_valid | out_ready.
//   SKID_EN = 1 : a main register plus a skid register, run by an
//                 EMPTY/FULL/SKID state machine. in_ready comes straight from
//                 a flop, so there is no combinational path from out_ready
//                 to in_ready.
//
// Optional feature (compile-time macro PIPE_STAGE_PERF_EN):
//   when the macro is defined, saturating stall and flush counters of CNT_W
//   bits drive perf_stall_cnt and perf_flush_cnt. When it is undefined, both
//   outputs are tied to zero and no counter flops exist.
//
// Reset: rst is asynchronous and active-low.

module pipe_stage_reg #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int unsigned      SKID_EN    = 0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  // Occupancy of the skid variant. SKID means both registers hold a beat.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  if (SKID_EN == 0) begin : g_single

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;
    logic             drain;

    // Upstream may push whenever the slot is free or is emptied this cycle.
    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign drain    = valid_q & out_ready;

    // Next-state logic. Priority is flush, then load, then drain to a bubble.
    always_comb begin
      // NOTE: every variable gets a default first, so no path through the
      // block can leave a value unassigned and infer a latch.
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
        data_d  = BUBBLE_VAL;
      end else if (accept) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (drain) begin
        valid_d = 1'b0;
        data_d  = BUBBLE_VAL;
      end
    end

    // Stage register with asynchronous reset to an empty bubble.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // NOTE: the payload is reset too, not only the valid bit. out_data
        // must read BUBBLE_VAL during reset, so no stale payload is visible.
        valid_q <= 1'b0;
        data_q  <= BUBBLE_VAL;
      end else begin
        // NOTE: state updates use non-blocking assignments, so every flop
        // samples values from before the edge and the order of statements
        // does not matter.
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

  end else begin : g_skid

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             drain;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q;
    assign drain    = (state_q != ST_EMPTY) & out_ready;

    // Next-state and datapath steering. flush overrides every transition.
    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
        data_d  = BUBBLE_VAL;
        skid_d  = BUBBLE_VAL;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              data_d  = in_data;
              state_d = ST_FULL;
            end
          end
          ST_FULL: begin
            if (accept && drain) begin
              data_d = in_data;
            end else if (accept) begin
              // Downstream is stalled. Park the beat that is already in flight.
              skid_d  = in_data;
              state_d = ST_SKID;
            end else if (drain) begin
              data_d  = BUBBLE_VAL;
              state_d = ST_EMPTY;
            end
          end
          ST_SKID: begin
            // in_ready is low here, so the only possible event is a drain.
            if (drain) begin
              data_d  = skid_q;
              skid_d  = BUBBLE_VAL;
              state_d = ST_FULL;
            end
          end
          default: begin
            state_d = ST_EMPTY;
            data_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
          end
        endcase
      end
      // Decoded from the next state, so in_ready leaves a flop with no
      // combinational logic after it.
      in_ready_d = (state_d != ST_SKID);
    end

    // State, ready flag, main register and skid register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
        data_q     <= BUBBLE_VAL;
        skid_q     <= BUBBLE_VAL;
      end else begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
        data_q     <= data_d;
        skid_q     <= skid_d;
      end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = data_q;

  end

`ifdef PIPE_STAGE_PERF_EN

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters. They hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;

`else

  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Two instances share one clock and reset:
//   u_skid   : WIDTH=32, BUBBLE_VAL=NOP, SKID_EN=1, CNT_W=4
//   u_single : WIDTH=8,  BUBBLE_VAL=0,   SKID_EN=0, CNT_W=4
// Inputs change 1 ns after the rising edge. Handshakes are sampled on the
// falling edge. Accepted beats go into a queue, and each delivered beat is
// popped from that queue and compared.

module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [3:0]  s_perf_stall, s_perf_flush;

  logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0]  n_in_data, n_out_data;
  logic [3:0]  n_perf_stall, n_perf_flush;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] s_q[$];
  logic [7:0]  n_q[$];
  int          s_deliv = 0;
  int          n_deliv = 0;
  logic [3:0]  stall_m = 4'h0;
  logic [3:0]  flush_m = 4'h0;

  pipe_stage_reg #(
    .WIDTH(32), .BUBBLE_VAL(NOP), .SKID_EN(1), .CNT_W(4)
  ) u_skid (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .perf_stall_cnt(s_perf_stall), .perf_flush_cnt(s_perf_flush)
  );

  pipe_stage_reg #(
    .WIDTH(8), .BUBBLE_VAL(8'h00), .SKID_EN(0), .CNT_W(4)
  ) u_single (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .perf_stall_cnt(n_perf_stall), .perf_flush_cnt(n_perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic s_drive(input logic v, input logic [31:0] d, input logic r);
    s_in_valid = v; s_in_data = d; s_out_ready = r;
  endtask

  task automatic n_drive(input logic v, input logic [7:0] d, input logic r);
    n_in_valid = v; n_in_data = d; n_out_ready = r;
  endtask

  // One clock cycle: score both instances at the falling edge, then step to
  // 1 ns after the next rising edge.
  task automatic tick();
    logic [31:0] e32;
    logic [7:0]  e8;
    @(negedge clk);
    if (s_out_valid && s_out_ready) begin
      checks++;
      s_deliv++;
      if (s_q.size() == 0) begin
        errors++;
        $display("FAIL s_sb_extra: delivered %h, expected no beat", s_out_data);
      end else begin
        e32 = s_q.pop_front();
        if (s_out_data !== e32) begin
          errors++;
          $display("FAIL s_sb_data: got %h, expected %h", s_out_data, e32);
        end
      end
    end
    if (s_flush) s_q.delete();
    else if (s_in_valid && s_in_ready) s_q.push_back(s_in_data);
    if (s_out_valid && !s_out_ready && stall_m != 4'hF) stall_m++;
    if (s_flush && flush_m != 4'hF) flush_m++;

    if (n_out_valid && n_out_ready) begin
      checks++;
      n_deliv++;
      if (n_q.size() == 0) begin
        errors++;
        $display("FAIL n_sb_extra: delivered %h, expected no beat", n_out_data);
      end else begin
        e8 = n_q.pop_front();
        if (n_out_data !== e8) begin
          errors++;
          $display("FAIL n_sb_data: got %h, expected %h", n_out_data, e8);
        end
      end
    end
    if (n_flush) n_q.delete();
    else if (n_in_valid && n_in_ready) n_q.push_back(n_in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_flush = 1'b0; n_flush = 1'b0;
    s_drive(1'b0, 32'h0, 1'b0);
    n_drive(1'b0, 8'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_skid: valid=%b data=%h ready=%b, expected 0 %h 1",
               s_out_valid, s_out_data, s_in_ready, NOP);
    end
    checks++;
    if (n_out_valid !== 1'b0 || n_out_data !== 8'h00 || n_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_single: valid=%b data=%h ready=%b, expected 0 00 1",
               n_out_valid, n_out_data, n_in_ready);
    end
    checks++;
    if (s_perf_stall !== 4'h0 || s_perf_flush !== 4'h0 ||
        n_perf_stall !== 4'h0 || n_perf_flush !== 4'h0) begin
      errors++;
      $display("FAIL reset_perf: counters %h %h %h %h, expected all 0",
               s_perf_stall, s_perf_flush, n_perf_stall, n_perf_flush);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: skid=%b single=%b, expected 1 1",
               s_in_ready, n_in_ready);
    end
  endtask

  task automatic test_first_beat();
    checks++;
    if (s_out_data !== NOP) begin
      errors++;
      $display("FAIL first_bubble: got %h, expected %h", s_out_data, NOP);
    end
    s_drive(1'b1, 32'h0040_0093, 1'b1);
    tick();
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'h0040_0093) begin
      errors++;
      $display("FAIL first_beat: valid=%b data=%h, expected 1 00400093",
               s_out_valid, s_out_data);
    end
    s_drive(1'b0, 32'hDEAD_BEEF, 1'b1);
    tick();
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP) begin
      errors++;
      $display("FAIL first_drain: valid=%b data=%h, expected 0 %h",
               s_out_valid, s_out_data, NOP);
    end
  endtask

  task automatic test_skid_backpressure();
    int base;
    base = s_deliv;
    s_drive(1'b1, 32'd1, 1'b1); tick();
    s_drive(1'b1, 32'd2, 1'b0); tick();
    checks++;
    if (s_in_ready !== 1'b0 || s_out_data !== 32'd1) begin
      errors++;
      $display("FAIL skid_full: ready=%b data=%h, expected 0 1", s_in_ready, s_out_data);
    end
    s_drive(1'b1, 32'd3, 1'b0); tick();
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'd1 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL skid_hold: valid=%b data=%h ready=%b, expected 1 1 0",
               s_out_valid, s_out_data, s_in_ready);
    end
    s_drive(1'b1, 32'd3, 1'b1);
    #1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL skid_ready_comb: got %b, expected 0", s_in_ready);
    end
    tick();
    s_drive(1'b1, 32'd3, 1'b1); tick();
    s_drive(1'b1, 32'd4, 1'b1); tick();
    s_drive(1'b0, 32'd0, 1'b1); tick();
    checks++;
    if (s_deliv - base != 4 || s_q.size() != 0 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_count: delivered %0d left %0d valid=%b, expected 4 0 0",
               s_deliv - base, s_q.size(), s_out_valid);
    end
  endtask

  task automatic test_single_handoff();
    n_drive(1'b1, 8'h3C, 1'b0); tick();
    n_drive(1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if (n_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_stall_ready: got %b, expected 0", n_in_ready);
    end
    tick();
    checks++;
    if (n_out_data !== 8'h3C || n_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: valid=%b data=%h, expected 1 3c", n_out_valid, n_out_data);
    end
    n_drive(1'b1, 8'hA5, 1'b1);
    #1;
    checks++;
    if (n_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_comb: got %b, expected 1", n_in_ready);
    end
    tick();
    checks++;
    if (n_out_valid !== 1'b1 || n_out_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_a5: valid=%b data=%h, expected 1 a5", n_out_valid, n_out_data);
    end
    n_drive(1'b0, 8'hFF, 1'b1); tick();
    checks++;
    if (n_out_valid !== 1'b0 || n_out_data !== 8'h00) begin
      errors++;
      $display("FAIL single_bubble: valid=%b data=%h, expected 0 00", n_out_valid, n_out_data);
    end
  endtask

  task automatic test_flush();
    s_drive(1'b1, 32'd7, 1'b0); tick();
    s_drive(1'b1, 32'd8, 1'b0); tick();
    checks++;
    if (s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: ready=%b, expected 0", s_in_ready);
    end
    s_flush = 1'b1;
    s_drive(1'b1, 32'd9, 1'b0); tick();
    s_flush = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid: valid=%b data=%h ready=%b, expected 0 %h 1",
               s_out_valid, s_out_data, s_in_ready, NOP);
    end
    s_drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost: valid=%b data=%h, expected 0", s_out_valid, s_out_data);
      end
    end
    // The single register delivers its beat and flushes in the same cycle.
    n_drive(1'b1, 8'h11, 1'b0); tick();
    n_flush = 1'b1;
    n_drive(1'b1, 8'h22, 1'b1); tick();
    n_flush = 1'b0;
    n_drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (n_out_valid !== 1'b0 || n_out_data !== 8'h00) begin
      errors++;
      $display("FAIL flush_single: valid=%b data=%h, expected 0 00", n_out_valid, n_out_data);
    end
  endtask

  task automatic test_async_reset();
    s_drive(1'b1, 32'h55, 1'b0); tick();
    checks++;
    if (s_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: valid=%b, expected 1", s_out_valid);
    end
    s_drive(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP) begin
      errors++;
      $display("FAIL areset_now: valid=%b data=%h, expected 0 %h",
               s_out_valid, s_out_data, NOP);
    end
    s_q.delete(); n_q.delete();
    stall_m = 4'h0; flush_m = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_release: ready=%b valid=%b/%b, expected 1 0 0",
               s_in_ready, s_out_valid, n_out_valid);
    end
  endtask

  task automatic test_perf();
    logic [3:0] exp_s, exp_f;
    s_drive(1'b1, 32'hAB, 1'b0); tick();
    s_drive(1'b0, 32'h0, 1'b0);
    repeat (20) tick();
`ifdef PIPE_STAGE_PERF_EN
    exp_s = stall_m;
`else
    exp_s = 4'h0;
`endif
    checks++;
    if (s_perf_stall !== exp_s) begin
      errors++;
      $display("FAIL perf_stall: got %h, expected %h", s_perf_stall, exp_s);
    end
    s_drive(1'b0, 32'h0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      s_flush = 1'b1; tick();
      s_flush = 1'b0; tick();
    end
`ifdef PIPE_STAGE_PERF_EN
    exp_s = stall_m;
    exp_f = flush_m;
`else
    exp_s = 4'h0;
    exp_f = 4'h0;
`endif
    checks++;
    if (s_perf_flush !== exp_f || s_perf_stall !== exp_s) begin
      errors++;
      $display("FAIL perf_flush: flush=%h stall=%h, expected %h %h",
               s_perf_flush, s_perf_stall, exp_f, exp_s);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int i = 0; i < 300; i++) begin
      s_flush = ($urandom_range(0, 31) == 0);
      n_flush = ($urandom_range(0, 31) == 0);
      s_drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
      n_drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 2) != 0));
      tick();
    end
    s_flush = 1'b0; n_flush = 1'b0;
    s_drive(1'b0, 32'h0, 1'b1);
    n_drive(1'b0, 8'h0, 1'b1);
    guard = 0;
    while ((s_q.size() != 0 || n_q.size() != 0) && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (s_q.size() != 0 || n_q.size() != 0 || s_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: left %0d/%0d valid=%b/%b, expected 0 0 0 0",
               s_q.size(), n_q.size(), s_out_valid, n_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_skid_backpressure();
    test_single_handoff();
    test_flush();
    test_async_reset();
    test_perf();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
